// File: rtl/state_space_plant.sv
`default_nettype none
// ============================================================================
//  Module      : state_space_plant
//  Description : Fixed-point discrete state-space plant.
//                y[k] = C*x[k], then x[k+1] = A*x[k] + B*u[k], evaluated with
//                one shared multiply-accumulate per enabled clock, FSM driven.
//                Optional feature macro: PLANT_NOISE_EN (LFSR noise on Y).
//  Revision    : 1.0  initial release
// ============================================================================
module state_space_plant #(
  parameter int WIDTH     = 16,
  parameter int intDigits = 8,
  parameter int nos       = 2,
  parameter int noo       = 1,
  parameter int noi       = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               clk_en,
  input  logic                               load,
  input  logic                               start,
  input  logic [noi-1:0][WIDTH-1:0]          U,
  input  logic [nos-1:0][nos-1:0][WIDTH-1:0] A,
  input  logic [nos-1:0][noi-1:0][WIDTH-1:0] B,
  input  logic [noo-1:0][nos-1:0][WIDTH-1:0] C,
  input  logic [nos-1:0][WIDTH-1:0]          X0,
  output logic [noo-1:0][WIDTH-1:0]          Y,
  output logic [nos-1:0][WIDTH-1:0]          X,
  output logic                               busy,
  output logic                               done
);

  localparam int FRAC = WIDTH - intDigits;
  localparam int PW   = 2 * WIDTH;
  localparam int ACCW = PW + $clog2(nos + noi);
  localparam int CW   = $clog2(nos + noi + noo + 1);

  localparam logic [CW-1:0] C_LAST_YCOL = CW'(nos - 1);
  localparam logic [CW-1:0] C_LAST_XCOL = CW'(nos + noi - 1);
  localparam logic [CW-1:0] C_LAST_YROW = CW'(noo - 1);
  localparam logic [CW-1:0] C_LAST_XROW = CW'(nos - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC_Y, S_CALC_X, S_DONE} state_e;

  state_e                    state_q, state_d;
  logic [CW-1:0]             row_q, row_d, col_q, col_d;
  logic [ACCW-1:0]           acc_q, acc_d;
  logic [noi-1:0][WIDTH-1:0] u_q, u_d;
  logic [noo-1:0][WIDTH-1:0] y_q, y_d;
  logic [nos-1:0][WIDTH-1:0] x_q, x_d;
  logic [nos-1:0][WIDTH-1:0] xs_q, xs_d;

  logic [WIDTH-1:0]          w_op_a, w_op_b;
  logic signed [PW-1:0]      w_prod;
  logic [ACCW-1:0]           w_acc_sum;
  logic signed [ACCW-1:0]    w_shift, w_pre_y;
  logic                      w_y_write;

  // Clamp a scaled row result into the signed WIDTH-bit range.
  function automatic logic [WIDTH-1:0] sat_word(input logic signed [ACCW-1:0] v);
    logic signed [ACCW-1:0] vmax, vmin;
    vmax = $signed({{(ACCW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}});
    vmin = $signed({{(ACCW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}});
    if (v > vmax)      sat_word = {1'b0, {(WIDTH-1){1'b1}}};
    else if (v < vmin) sat_word = {1'b1, {(WIDTH-1){1'b0}}};
    else               sat_word = v[WIDTH-1:0];
  endfunction

  // Select the MAC operand pair for the current (row, column) position.
  always_comb begin
    w_op_a = '0;
    w_op_b = '0;
    if (state_q == S_CALC_Y) begin
      for (int i = 0; i < noo; i++)
        for (int k = 0; k < nos; k++)
          if (row_q == CW'(i) && col_q == CW'(k)) begin
            w_op_a = C[i][k];
            w_op_b = x_q[k];
          end
    end else if (state_q == S_CALC_X) begin
      for (int j = 0; j < nos; j++) begin
        for (int k = 0; k < nos; k++)
          if (row_q == CW'(j) && col_q == CW'(k)) begin
            w_op_a = A[j][k];
            w_op_b = x_q[k];
          end
        for (int m = 0; m < noi; m++)
          if (row_q == CW'(j) && col_q == CW'(nos + m)) begin
            w_op_a = B[j][m];
            w_op_b = u_q[m];
          end
      end
    end
  end

  // Multiply, accumulate (cleared at column 0) and floor-scale the row result.
  always_comb begin
    w_prod    = $signed(w_op_a) * $signed(w_op_b);
    w_acc_sum = ((col_q == '0) ? '0 : acc_q)
              + {{(ACCW-PW){w_prod[PW-1]}}, w_prod};
    w_shift   = $signed(w_acc_sum) >>> FRAC;
    w_y_write = (state_q == S_CALC_Y) && (col_q == C_LAST_YCOL);
  end

`ifdef PLANT_NOISE_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR (taps 16,14,13,11); steps once per Y element written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  lfsr_q <= 16'hACE1;
    else if (clk_en && w_y_write) lfsr_q <= {lfsr_q[14:0],
                                             lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // Four LSBs of the LFSR as signed -8..+7 LSB of measurement noise.
  always_comb w_pre_y = w_shift + {{(ACCW-4){lfsr_q[3]}}, lfsr_q[3:0]};
`else
  // Noise-free build: measurement is the exact scaled product sum.
  always_comb w_pre_y = w_shift;
`endif

  // Sequencer: next state, counters, accumulator, result and shadow registers.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    acc_d   = acc_q;
    u_d     = u_q;
    y_d     = y_q;
    x_d     = x_q;
    xs_d    = xs_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          x_d = X0;
        end else if (start) begin
          u_d     = U;
          row_d   = '0;
          col_d   = '0;
          state_d = S_CALC_Y;
        end
      end
      S_CALC_Y: begin
        acc_d = w_acc_sum;
        if (col_q == C_LAST_YCOL) begin
          for (int i = 0; i < noo; i++)
            if (row_q == CW'(i)) y_d[i] = sat_word(w_pre_y);
          col_d = '0;
          if (row_q == C_LAST_YROW) begin
            row_d   = '0;
            state_d = S_CALC_X;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      S_CALC_X: begin
        acc_d = w_acc_sum;
        if (col_q == C_LAST_XCOL) begin
          for (int j = 0; j < nos; j++)
            if (row_q == CW'(j)) xs_d[j] = sat_word(w_shift);
          col_d = '0;
          if (row_q == C_LAST_XROW) begin
            // Whole new state vector becomes visible in one edge.
            x_d     = xs_d;
            row_d   = '0;
            state_d = S_DONE;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; clk_en low freezes everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      acc_q   <= '0;
      u_q     <= '0;
      y_q     <= '0;
      x_q     <= '0;
      xs_q    <= '0;
    end else if (clk_en) begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      acc_q   <= acc_d;
      u_q     <= u_d;
      y_q     <= y_d;
      x_q     <= x_d;
      xs_q    <= xs_d;
    end
  end

  assign Y    = y_q;
  assign X    = x_q;
  assign busy = (state_q == S_CALC_Y) || (state_q == S_CALC_X);
  assign done = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_state_space_plant.sv
`default_nettype none
// ============================================================================
//  Module      : tb_state_space_plant
//  Description : Self-checking bench for state_space_plant against an
//                arithmetic reference of y=C*x, x'=A*x+B*u (Q8.8, floor, sat).
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_state_space_plant;
  localparam int W = 16, F = 8, NS = 2, NO = 1, NI = 1, LAT = 8;

  logic clk = 1'b0, reset = 1'b0, clk_en = 1'b1, load = 1'b0, start = 1'b0;
  logic [NI-1:0][W-1:0]        U;
  logic [NS-1:0][NS-1:0][W-1:0] A;
  logic [NS-1:0][NI-1:0][W-1:0] B;
  logic [NO-1:0][NS-1:0][W-1:0] C;
  logic [NS-1:0][W-1:0]        X0;
  logic [NO-1:0][W-1:0]        Y;
  logic [NS-1:0][W-1:0]        X;
  logic busy, done;

  int total = 0, bad = 0;
  longint mx[NS];
  longint my[NO];
  logic [15:0] mlfsr = 16'hACE1;

  state_space_plant #(.WIDTH(W), .intDigits(8), .nos(NS), .noo(NO), .noi(NI)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .load(load), .start(start),
    .U(U), .A(A), .B(B), .C(C), .X0(X0), .Y(Y), .X(X), .busy(busy), .done(done));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint sv(input logic [W-1:0] w);
    return longint'($signed(w));
  endfunction

  function automatic logic [W-1:0] lo(input longint v);
    return v[W-1:0];
  endfunction

  function automatic longint sat(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference plant step from the current bench-side A, B, C, U.
  task automatic model_step();
    longint nx[NS];
    longint s;
    int nz;
    for (int i = 0; i < NO; i++) begin
      s = 0;
      for (int k = 0; k < NS; k++) s += sv(C[i][k]) * mx[k];
      s = s >>> F;
`ifdef PLANT_NOISE_EN
      nz = mlfsr[3] ? int'(mlfsr[3:0]) - 16 : int'(mlfsr[3:0]);
      s += nz;
      mlfsr = {mlfsr[14:0], mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
`else
      nz = 0;
      s += nz;
`endif
      my[i] = sat(s);
    end
    for (int j = 0; j < NS; j++) begin
      s = 0;
      for (int k = 0; k < NS; k++) s += sv(A[j][k]) * mx[k];
      for (int m = 0; m < NI; m++) s += sv(B[j][m]) * sv(U[m]);
      nx[j] = sat(s >>> F);
    end
    for (int j = 0; j < NS; j++) mx[j] = nx[j];
  endtask

  task automatic do_load(input logic [W-1:0] x0a, input logic [W-1:0] x0b);
    X0[0] = x0a; X0[1] = x0b; load = 1'b1;
    tick();
    load = 1'b0;
    mx[0] = sv(x0a); mx[1] = sv(x0b);
    total++;
    if (X !== X0) begin
      bad++; $display("FAIL load_X got=%h want=%h", X, X0);
    end
  endtask

  // One full plant step with latency, busy, result and done-pulse checks.
  task automatic do_step(input string tag, input logic [W-1:0] u);
    int n, nb;
    U[0] = u; start = 1'b1;
    tick();
    start = 1'b0;
    model_step();
    n = 0; nb = 0;
    while (n < 40 && done !== 1'b1) begin
      if (busy === 1'b1) nb++;
      tick();
      n++;
    end
    total++;
    if (n != LAT) begin bad++; $display("FAIL %s latency got=%0d want=%0d", tag, n, LAT); end
    total++;
    if (nb != LAT) begin bad++; $display("FAIL %s busy_cycles got=%0d want=%0d", tag, nb, LAT); end
    for (int i = 0; i < NO; i++) begin
      total++;
      if (Y[i] !== lo(my[i])) begin bad++; $display("FAIL %s Y[%0d] got=%h want=%h", tag, i, Y[i], lo(my[i])); end
    end
    for (int j = 0; j < NS; j++) begin
      total++;
      if (X[j] !== lo(mx[j])) begin bad++; $display("FAIL %s X[%0d] got=%h want=%h", tag, j, X[j], lo(mx[j])); end
    end
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL %s after_done done=%b busy=%b want 0 0", tag, done, busy);
    end
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (Y !== '0 || X !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL reset_state Y=%h X=%h busy=%b done=%b want all 0", Y, X, busy, done);
    end
    reset = 1'b1;
    tick();
    for (int j = 0; j < NS; j++) mx[j] = 0;
  endtask

  task automatic test_spec_vectors();
    A[0][0] = 16'h0080; A[0][1] = 16'h0000; A[1][0] = 16'h0000; A[1][1] = 16'h0019;
    B[0][0] = 16'h0300; B[1][0] = 16'h0500;
    C[0][0] = 16'h0500; C[0][1] = 16'h0700;
    do_load(16'h0000, 16'h0000);
    do_step("vec1", 16'h0100);
    total++;
    if (X[0] !== 16'h0300 || X[1] !== 16'h0500) begin bad++; $display("FAIL vec1_X got=%h want=05000300", X); end
`ifndef PLANT_NOISE_EN
    total++;
    if (Y[0] !== 16'h0000) begin bad++; $display("FAIL vec1_Y got=%h want=0000", Y[0]); end
`endif
    do_step("vec2", 16'h0000);
    total++;
    if (X[0] !== 16'h0180 || X[1] !== 16'h007D) begin bad++; $display("FAIL vec2_X got=%h want=007d0180", X); end
`ifndef PLANT_NOISE_EN
    total++;
    if (Y[0] !== 16'h3200) begin bad++; $display("FAIL vec2_Y got=%h want=3200", Y[0]); end
`endif
    do_load(16'h6400, 16'h0000);
    do_step("vec3_pos", 16'h0000);
    total++;
    if (Y[0] !== 16'h7FFF) begin bad++; $display("FAIL vec3_sat_hi got=%h want=7fff", Y[0]); end
    do_load(16'h9C00, 16'h0000);
    do_step("vec3_neg", 16'h0000);
    total++;
    if (Y[0] !== 16'h8000) begin bad++; $display("FAIL vec3_sat_lo got=%h want=8000", Y[0]); end
    do_load(16'h0000, 16'h0000);
    do_step("vec4a", 16'hFF00);
    total++;
    if (X[0] !== 16'hFD00 || X[1] !== 16'hFB00) begin bad++; $display("FAIL vec4_X got=%h want=fb00fd00", X); end
    do_step("vec4b", 16'h0000);
`ifndef PLANT_NOISE_EN
    total++;
    if (Y[0] !== 16'hCE00) begin bad++; $display("FAIL vec4_Y got=%h want=ce00", Y[0]); end
`endif
  endtask

  task automatic test_start_busy();
    int n;
    logic [NS-1:0][W-1:0] xh;
    U[0] = 16'h0040; start = 1'b1;
    tick();
    start = 1'b0;
    model_step();
    n = 0;
    for (int c = 0; c < 6; c++) begin
      start = 1'b1; load = 1'b1;
      U[0] = W'($urandom); X0[0] = W'($urandom); X0[1] = W'($urandom);
      tick();
      n++;
    end
    start = 1'b0; load = 1'b0;
    while (n < 40 && done !== 1'b1) begin tick(); n++; end
    total++;
    if (n != LAT) begin bad++; $display("FAIL busy_ignore latency got=%0d want=%0d", n, LAT); end
    total++;
    if (Y[0] !== lo(my[0]) || X[0] !== lo(mx[0]) || X[1] !== lo(mx[1])) begin
      bad++; $display("FAIL busy_ignore result Y=%h X=%h want Y=%h X=%h%h", Y[0], X, lo(my[0]), lo(mx[1]), lo(mx[0]));
    end
    xh = X;
    tick(); tick();
    total++;
    if (busy !== 1'b0 || X !== xh) begin bad++; $display("FAIL busy_ignore no_queue busy=%b X=%h want 0 %h", busy, X, xh); end
  endtask

  task automatic test_clk_en();
    int n;
    logic [NO-1:0][W-1:0] ys;
    logic [NS-1:0][W-1:0] xsn;
    U[0] = 16'hFFC0; start = 1'b1;
    tick();
    start = 1'b0;
    model_step();
    tick(); tick(); tick();
    clk_en = 1'b0;
    ys = Y; xsn = X;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++;
      if (Y !== ys || X !== xsn || busy !== 1'b1 || done !== 1'b0) begin
        bad++; $display("FAIL clk_en_freeze cyc=%0d Y=%h X=%h busy=%b done=%b want Y=%h X=%h 1 0", c, Y, X, busy, done, ys, xsn);
      end
    end
    clk_en = 1'b1;
    n = 0;
    while (n < 40 && done !== 1'b1) begin tick(); n++; end
    total++;
    if (n != LAT - 3) begin bad++; $display("FAIL clk_en_resume edges got=%0d want=%0d", n, LAT - 3); end
    total++;
    if (Y[0] !== lo(my[0]) || X[0] !== lo(mx[0]) || X[1] !== lo(mx[1])) begin
      bad++; $display("FAIL clk_en_result Y=%h X=%h want Y=%h X=%h%h", Y[0], X, lo(my[0]), lo(mx[1]), lo(mx[0]));
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int seen;
    U[0] = 16'h0100; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2 reset = 1'b0;
    #1;
    total++;
    if (X !== '0 || Y !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL reset_mid X=%h Y=%h busy=%b done=%b want all 0", X, Y, busy, done);
    end
    reset = 1'b1;
    for (int j = 0; j < NS; j++) mx[j] = 0;
    mlfsr = 16'hACE1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL reset_mid_abort active_cycles got=%0d want=0", seen); end
    do_step("after_reset", 16'h0100);
  endtask

  task automatic test_random();
    for (int it = 0; it < 16; it++) begin
      for (int j = 0; j < NS; j++)
        for (int k = 0; k < NS; k++)
          A[j][k] = (it % 2 == 0) ? W'($urandom_range(0, 16'h01FF)) - 16'h0100 : W'($urandom);
      for (int j = 0; j < NS; j++) B[j][0] = W'($urandom_range(0, 16'h07FF)) - 16'h0400;
      for (int k = 0; k < NS; k++) C[0][k] = W'($urandom_range(0, 16'h07FF)) - 16'h0400;
      if ($urandom_range(0, 3) == 0) do_load(W'($urandom), W'($urandom));
      do_step("random", W'($urandom));
    end
  endtask

  initial begin
    U = '0; A = '0; B = '0; C = '0; X0 = '0;
    test_reset();
    test_spec_vectors();
    test_start_busy();
    test_clk_en();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
